// File: rtl/uart16550_lite_ctrl_pkg.sv
// Shared definitions for the UART16550 lite-port controller: register map,
// LSR bit positions, AXI response codes and the sequencing FSM states.
package uart16550_lite_ctrl_pkg;

  localparam int unsigned AXI_ADDR_W = 13;

  // Register offsets relative to the UART register block base
  localparam logic [AXI_ADDR_W-1:0] OFF_RBR_THR_DLL = 13'h000;
  localparam logic [AXI_ADDR_W-1:0] OFF_IER_DLM     = 13'h004;
  localparam logic [AXI_ADDR_W-1:0] OFF_FCR         = 13'h008;
  localparam logic [AXI_ADDR_W-1:0] OFF_LCR         = 13'h00C;
  localparam logic [AXI_ADDR_W-1:0] OFF_LSR         = 13'h014;

  // LSR bit indices
  localparam int unsigned LSR_DR   = 0;
  localparam int unsigned LSR_THRE = 5;

  // LCR divisor-latch access bit
  localparam logic [7:0] LCR_DLAB = 8'h80;

  // AXI response code for a clean transfer
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [3:0] {
    S_W_LCR_DLAB,
    S_W_DLL,
    S_W_DLM,
    S_W_LCR,
    S_W_FCR,
    S_W_IER,
    S_GAP,
    S_R_LSR,
    S_R_RBR,
    S_TX_ACCEPT,
    S_W_THR
  } ctrl_state_e;

endpackage

// File: rtl/uart16550_lite_ctrl_axil.sv
// One-shot AXI4-Lite master engine: runs a single write or read per start
// pulse and reports completion with the response code and read byte.
module axil_single_master
  import uart16550_lite_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  i_start_wr,
  input  logic                  i_start_rd,
  input  logic [AXI_ADDR_W-1:0] i_addr,
  input  logic [7:0]            i_wdata,
  output logic                  o_done,
  output logic [7:0]            o_rdata,
  output logic [1:0]            o_resp,
  output logic [AXI_ADDR_W-1:0] m_aw_addr,
  output logic                  m_aw_valid,
  input  logic                  m_aw_ready,
  output logic [31:0]           m_w_data,
  output logic [3:0]            m_w_strb,
  output logic                  m_w_valid,
  input  logic                  m_w_ready,
  input  logic [1:0]            m_b_resp,
  input  logic                  m_b_valid,
  output logic                  m_b_ready,
  output logic [AXI_ADDR_W-1:0] m_ar_addr,
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  input  logic [31:0]           m_r_data,
  input  logic [1:0]            m_r_resp,
  input  logic                  m_r_valid,
  output logic                  m_r_ready
);

  logic                  r_aw_valid;
  logic                  r_w_valid;
  logic                  r_b_ready;
  logic                  r_wr_busy;
  logic                  r_ar_valid;
  logic                  r_r_ready;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [7:0]            r_wdata;

  logic w_busy;
  logic w_aw_ok;
  logic w_w_ok;
  logic w_unused_rdata;

  assign w_busy  = r_wr_busy | r_ar_valid | r_r_ready;
  // Address/data channel counts as finished if already handshaken or handshaking now
  assign w_aw_ok = ~r_aw_valid | m_aw_ready;
  assign w_w_ok  = ~r_w_valid  | m_w_ready;

  // Handshake sequencing for both channels; payload latched at start so it stays stable
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_wr_busy  <= 1'b0;
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      if (i_start_wr && !w_busy) begin
        r_addr     <= i_addr;
        r_wdata    <= i_wdata;
        r_aw_valid <= 1'b1;
        r_w_valid  <= 1'b1;
        r_wr_busy  <= 1'b1;
      end else if (i_start_rd && !w_busy) begin
        r_addr     <= i_addr;
        r_ar_valid <= 1'b1;
      end
      if (r_aw_valid && m_aw_ready) r_aw_valid <= 1'b0;
      if (r_w_valid && m_w_ready)   r_w_valid  <= 1'b0;
      if (r_wr_busy && !r_b_ready && w_aw_ok && w_w_ok) r_b_ready <= 1'b1;
      if (r_b_ready && m_b_valid) begin
        r_b_ready <= 1'b0;
        r_wr_busy <= 1'b0;
      end
      if (r_ar_valid && m_ar_ready) begin
        r_ar_valid <= 1'b0;
        r_r_ready  <= 1'b1;
      end
      if (r_r_ready && m_r_valid) r_r_ready <= 1'b0;
    end
  end

  assign m_aw_addr  = r_addr;
  assign m_aw_valid = r_aw_valid;
  assign m_w_data   = {24'h0, r_wdata};
  assign m_w_strb   = 4'h1;
  assign m_w_valid  = r_w_valid;
  assign m_b_ready  = r_b_ready;
  assign m_ar_addr  = r_addr;
  assign m_ar_valid = r_ar_valid;
  assign m_r_ready  = r_r_ready;

  assign o_done  = (r_b_ready & m_b_valid) | (r_r_ready & m_r_valid);
  assign o_resp  = r_b_ready ? m_b_resp : m_r_resp;
  assign o_rdata = m_r_data[7:0];

  assign w_unused_rdata = ^m_r_data[31:8];

endmodule

// File: rtl/uart16550_lite_ctrl.sv
// AXI4-Lite master owning a UART16550: programs line settings after reset,
// then polls LSR and bridges TX/RX byte streams to THR/RBR.
module uart16550_lite_ctrl
  import uart16550_lite_ctrl_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR = 13'h1000,
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter logic [7:0]  LCR_VAL   = 8'h03,
  parameter logic [7:0]  FCR_VAL   = 8'h07,
  parameter logic [7:0]  POLL_GAP  = 8'd4
) (
  input  logic        clock,
  input  logic        resetn,
  output logic [12:0] m_aw_addr,
  output logic        m_aw_valid,
  input  logic        m_aw_ready,
  output logic [31:0] m_w_data,
  output logic [3:0]  m_w_strb,
  output logic        m_w_valid,
  input  logic        m_w_ready,
  input  logic [1:0]  m_b_resp,
  input  logic        m_b_valid,
  output logic        m_b_ready,
  output logic [12:0] m_ar_addr,
  output logic        m_ar_valid,
  input  logic        m_ar_ready,
  input  logic [31:0] m_r_data,
  input  logic [1:0]  m_r_resp,
  input  logic        m_r_valid,
  output logic        m_r_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic        reinit,
  output logic        init_done,
  output logic        bus_err
);

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;

  logic        r_issued;
  logic        r_reinit_pend;
  logic [7:0]  r_gap_cnt;
  logic        r_last_rx;
  logic [7:0]  r_tx_byte;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_init_done;
  logic        r_bus_err;

  logic        w_is_wr;
  logic        w_is_rd;
  logic        w_start_wr;
  logic        w_start_rd;
  logic [12:0] w_addr;
  logic [7:0]  w_wdata;
  logic        w_done;
  logic [7:0]  w_rdata;
  logic [1:0]  w_resp;
  logic        w_reinit_req;
  logic        w_reinit_go;
  logic        w_enter_gap;
  logic        w_dr_ok;
  logic        w_tx_ok;

  assign w_reinit_req = r_reinit_pend | reinit;
  assign w_dr_ok      = w_rdata[LSR_DR] & ~r_rx_valid;
  assign w_tx_ok      = w_rdata[LSR_THRE] & tx_valid;
  assign w_start_wr   = w_is_wr & ~r_issued;
  assign w_start_rd   = w_is_rd & ~r_issued;

  // Next-state, bus request and register-access selection
  always_comb begin
    w_state_nxt = r_state;
    w_is_wr     = 1'b0;
    w_is_rd     = 1'b0;
    w_addr      = BASE_ADDR + OFF_RBR_THR_DLL;
    w_wdata     = '0;
    w_enter_gap = 1'b0;
    w_reinit_go = 1'b0;
    case (r_state)
      S_W_LCR_DLAB: begin
        w_is_wr = 1'b1;
        w_addr  = BASE_ADDR + OFF_LCR;
        w_wdata = LCR_DLAB | LCR_VAL;
        if (w_done) w_state_nxt = S_W_DLL;
      end
      S_W_DLL: begin
        w_is_wr = 1'b1;
        w_wdata = DIVISOR[7:0];
        if (w_done) w_state_nxt = S_W_DLM;
      end
      S_W_DLM: begin
        w_is_wr = 1'b1;
        w_addr  = BASE_ADDR + OFF_IER_DLM;
        w_wdata = DIVISOR[15:8];
        if (w_done) w_state_nxt = S_W_LCR;
      end
      S_W_LCR: begin
        w_is_wr = 1'b1;
        w_addr  = BASE_ADDR + OFF_LCR;
        w_wdata = LCR_VAL & ~LCR_DLAB;
        if (w_done) w_state_nxt = S_W_FCR;
      end
      S_W_FCR: begin
        w_is_wr = 1'b1;
        w_addr  = BASE_ADDR + OFF_FCR;
        w_wdata = FCR_VAL;
        if (w_done) w_state_nxt = S_W_IER;
      end
      S_W_IER: begin
        w_is_wr = 1'b1;
        w_addr  = BASE_ADDR + OFF_IER_DLM;
        if (w_done) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_reinit_req) begin
          w_state_nxt = S_W_LCR_DLAB;
          w_reinit_go = 1'b1;
        end else if (r_gap_cnt == '0) begin
          w_state_nxt = S_R_LSR;
        end
      end
      S_R_LSR: begin
        w_is_rd = 1'b1;
        w_addr  = BASE_ADDR + OFF_LSR;
        if (w_done) begin
          // Both sides eligible: serve the one not served last
          if (w_dr_ok && (!w_tx_ok || !r_last_rx)) w_state_nxt = S_R_RBR;
          else if (w_tx_ok)                        w_state_nxt = S_TX_ACCEPT;
          else                                     w_state_nxt = S_GAP;
        end
      end
      S_R_RBR: begin
        w_is_rd = 1'b1;
        if (w_done) w_state_nxt = S_GAP;
      end
      S_TX_ACCEPT: begin
        w_state_nxt = S_W_THR;
      end
      S_W_THR: begin
        w_is_wr = 1'b1;
        w_wdata = r_tx_byte;
        if (w_done) w_state_nxt = S_GAP;
      end
      default: w_state_nxt = S_W_LCR_DLAB;
    endcase
    // A pending reinit redirects any entry into GAP back to the init sequence
    if (w_state_nxt == S_GAP && r_state != S_GAP) begin
      w_enter_gap = 1'b1;
      if (w_reinit_req) begin
        w_state_nxt = S_W_LCR_DLAB;
        w_reinit_go = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_W_LCR_DLAB;
    else         r_state <= w_state_nxt;
  end

  // Control flags, gap counter, stream slots and status bits
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_issued      <= 1'b0;
      r_reinit_pend <= 1'b0;
      r_gap_cnt     <= POLL_GAP;
      r_last_rx     <= 1'b0;
      r_tx_byte     <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_init_done   <= 1'b0;
      r_bus_err     <= 1'b0;
    end else begin
      if (w_done)                        r_issued <= 1'b0;
      else if (w_start_wr || w_start_rd) r_issued <= 1'b1;

      if (w_reinit_go) r_reinit_pend <= 1'b0;
      else if (reinit) r_reinit_pend <= 1'b1;

      if (w_enter_gap)                        r_gap_cnt <= POLL_GAP;
      else if (r_state == S_GAP && r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 8'd1;

      if (r_state == S_R_LSR && w_done) begin
        if (w_state_nxt == S_R_RBR)          r_last_rx <= 1'b1;
        else if (w_state_nxt == S_TX_ACCEPT) r_last_rx <= 1'b0;
      end

      if (r_state == S_TX_ACCEPT) r_tx_byte <= tx_data;

      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (r_state == S_R_RBR && w_done) begin
        r_rx_data  <= w_rdata;
        r_rx_valid <= 1'b1;
      end

      if (w_reinit_go)                      r_init_done <= 1'b0;
      else if (r_state == S_W_IER && w_done) r_init_done <= 1'b1;

      if (w_done && w_resp != RESP_OKAY) r_bus_err <= 1'b1;
    end
  end

  assign tx_ready  = (r_state == S_TX_ACCEPT);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign init_done = r_init_done;
  assign bus_err   = r_bus_err;

  axil_single_master u_axil (
    .clock      (clock),
    .resetn     (resetn),
    .i_start_wr (w_start_wr),
    .i_start_rd (w_start_rd),
    .i_addr     (w_addr),
    .i_wdata    (w_wdata),
    .o_done     (w_done),
    .o_rdata    (w_rdata),
    .o_resp     (w_resp),
    .m_aw_addr  (m_aw_addr),
    .m_aw_valid (m_aw_valid),
    .m_aw_ready (m_aw_ready),
    .m_w_data   (m_w_data),
    .m_w_strb   (m_w_strb),
    .m_w_valid  (m_w_valid),
    .m_w_ready  (m_w_ready),
    .m_b_resp   (m_b_resp),
    .m_b_valid  (m_b_valid),
    .m_b_ready  (m_b_ready),
    .m_ar_addr  (m_ar_addr),
    .m_ar_valid (m_ar_valid),
    .m_ar_ready (m_ar_ready),
    .m_r_data   (m_r_data),
    .m_r_resp   (m_r_resp),
    .m_r_valid  (m_r_valid),
    .m_r_ready  (m_r_ready)
  );

endmodule

// File: tb/tb_uart16550_lite_ctrl.sv
// Directed bench for uart16550_lite_ctrl with a small reactive AXI-Lite slave.
module tb_uart16550_lite_ctrl;

  logic        clock;
  logic        resetn;
  logic [12:0] m_aw_addr;
  logic        m_aw_valid;
  logic        m_aw_ready;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic        m_w_valid;
  logic        m_w_ready;
  logic [1:0]  m_b_resp;
  logic        m_b_valid;
  logic        m_b_ready;
  logic [12:0] m_ar_addr;
  logic        m_ar_valid;
  logic        m_ar_ready;
  logic [31:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_valid;
  logic        m_r_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reinit;
  logic        init_done;
  logic        bus_err;

  int total;
  int bad;

  // slave configuration, driven by the tests
  logic [1:0] cfg_b_resp;
  logic [7:0] cfg_lsr;
  logic [7:0] cfg_rbr;

  // slave internals and logs
  logic        s_aw_got, s_w_got;
  logic [12:0] s_awaddr, s_raddr;
  logic [7:0]  s_wdata;
  logic [3:0]  s_wstrb;
  logic [12:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [3:0]  wr_strb_q[$];
  logic [12:0] rd_addr_q[$];
  int          op_q[$];      // 1 = RBR read, 2 = THR write
  int          rbr_cnt, lsr_cnt, txr_cnt;

  uart16550_lite_ctrl #(
    .BASE_ADDR (13'h1000),
    .DIVISOR   (16'd27),
    .LCR_VAL   (8'h03),
    .FCR_VAL   (8'h07),
    .POLL_GAP  (8'd4)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .m_aw_addr  (m_aw_addr),
    .m_aw_valid (m_aw_valid),
    .m_aw_ready (m_aw_ready),
    .m_w_data   (m_w_data),
    .m_w_strb   (m_w_strb),
    .m_w_valid  (m_w_valid),
    .m_w_ready  (m_w_ready),
    .m_b_resp   (m_b_resp),
    .m_b_valid  (m_b_valid),
    .m_b_ready  (m_b_ready),
    .m_ar_addr  (m_ar_addr),
    .m_ar_valid (m_ar_valid),
    .m_ar_ready (m_ar_ready),
    .m_r_data   (m_r_data),
    .m_r_resp   (m_r_resp),
    .m_r_valid  (m_r_valid),
    .m_r_ready  (m_r_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .reinit     (reinit),
    .init_done  (init_done),
    .bus_err    (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reactive slave: b follows both address/data handshakes, r follows ar
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_b_valid <= 1'b0;
      m_b_resp  <= 2'b00;
      m_r_valid <= 1'b0;
      m_r_data  <= '0;
      s_aw_got  <= 1'b0;
      s_w_got   <= 1'b0;
      s_awaddr  <= '0;
      s_raddr   <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
    end else begin
      if (m_aw_valid && m_aw_ready) begin
        s_aw_got <= 1'b1;
        s_awaddr <= m_aw_addr;
      end
      if (m_w_valid && m_w_ready) begin
        s_w_got <= 1'b1;
        s_wdata <= m_w_data[7:0];
        s_wstrb <= m_w_strb;
      end
      if (!m_b_valid && (s_aw_got || (m_aw_valid && m_aw_ready))
                     && (s_w_got  || (m_w_valid  && m_w_ready))) begin
        m_b_valid <= 1'b1;
        m_b_resp  <= cfg_b_resp;
      end
      if (m_b_valid && m_b_ready) begin
        m_b_valid <= 1'b0;
        s_aw_got  <= 1'b0;
        s_w_got   <= 1'b0;
        wr_addr_q.push_back(s_awaddr);
        wr_data_q.push_back(s_wdata);
        wr_strb_q.push_back(s_wstrb);
        if (s_awaddr == 13'h1000) op_q.push_back(2);
      end
      if (m_ar_valid && m_ar_ready && !m_r_valid) begin
        m_r_valid <= 1'b1;
        s_raddr   <= m_ar_addr;
        if (m_ar_addr == 13'h1014)      m_r_data <= {24'h0, cfg_lsr};
        else if (m_ar_addr == 13'h1000) m_r_data <= {24'h0, cfg_rbr};
        else                            m_r_data <= '0;
      end
      if (m_r_valid && m_r_ready) begin
        m_r_valid <= 1'b0;
        rd_addr_q.push_back(s_raddr);
        if (s_raddr == 13'h1000) begin
          op_q.push_back(1);
          rbr_cnt <= rbr_cnt + 1;
        end
        if (s_raddr == 13'h1014) lsr_cnt <= lsr_cnt + 1;
      end
    end
  end

  // Count cycles with tx_ready high
  always @(negedge clock) begin
    if (tx_ready) txr_cnt <= txr_cnt + 1;
  end

  task automatic drive_tx(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    total += 10;
    if (m_aw_valid !== 1'b0) begin bad++; $display("FAIL rst_aw_valid got=%b exp=0", m_aw_valid); end
    if (m_w_valid  !== 1'b0) begin bad++; $display("FAIL rst_w_valid got=%b exp=0", m_w_valid); end
    if (m_b_ready  !== 1'b0) begin bad++; $display("FAIL rst_b_ready got=%b exp=0", m_b_ready); end
    if (m_ar_valid !== 1'b0) begin bad++; $display("FAIL rst_ar_valid got=%b exp=0", m_ar_valid); end
    if (m_r_ready  !== 1'b0) begin bad++; $display("FAIL rst_r_ready got=%b exp=0", m_r_ready); end
    if (tx_ready   !== 1'b0) begin bad++; $display("FAIL rst_tx_ready got=%b exp=0", tx_ready); end
    if (rx_valid   !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
    if (rx_data    !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
    if (init_done  !== 1'b0) begin bad++; $display("FAIL rst_init_done got=%b exp=0", init_done); end
    if (bus_err    !== 1'b0) begin bad++; $display("FAIL rst_bus_err got=%b exp=0", bus_err); end
    resetn = 1'b1;
  endtask

  task automatic test_init();
    logic [12:0] ea [6];
    logic [7:0]  ed [6];
    bit seen;
    int snap;
    ea = '{13'h100C, 13'h1000, 13'h1004, 13'h100C, 13'h1008, 13'h1004};
    ed = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};
    snap = wr_addr_q.size();
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (m_b_valid && m_b_ready && wr_addr_q.size() == snap + 5) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL init_sixth_b got=timeout exp=handshake");
    end else begin
      total++;
      if (init_done !== 1'b0) begin bad++; $display("FAIL init_done_early got=%b exp=0", init_done); end
      @(negedge clock);
      total++;
      if (init_done !== 1'b1) begin bad++; $display("FAIL init_done_rise got=%b exp=1", init_done); end
    end
    total++;
    if (wr_addr_q.size() !== snap + 6) begin
      bad++; $display("FAIL init_write_count got=%0d exp=%0d", wr_addr_q.size() - snap, 6);
    end else begin
      for (int k = 0; k < 6; k++) begin
        total += 3;
        if (wr_addr_q[snap+k] !== ea[k]) begin bad++; $display("FAIL init_addr%0d got=%h exp=%h", k, wr_addr_q[snap+k], ea[k]); end
        if (wr_data_q[snap+k] !== ed[k]) begin bad++; $display("FAIL init_data%0d got=%h exp=%h", k, wr_data_q[snap+k], ed[k]); end
        if (wr_strb_q[snap+k] !== 4'h1)  begin bad++; $display("FAIL init_strb%0d got=%h exp=1", k, wr_strb_q[snap+k]); end
      end
    end
  endtask

  task automatic test_aw_stall();
    bit ok;
    bit seen;
    int snap;
    logic [12:0] a0;
    snap = wr_addr_q.size();
    m_aw_ready = 1'b0;
    cfg_lsr = 8'h20;
    drive_tx(8'h33, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_tx_accept got=timeout exp=tx_ready"); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_aw_valid) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL stall_aw_valid got=0 exp=1"); end
    a0 = m_aw_addr;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      total += 4;
      if (m_aw_valid !== 1'b1) begin bad++; $display("FAIL stall_aw_hold%0d got=%b exp=1", c, m_aw_valid); end
      if (m_aw_addr !== 13'h1000) begin bad++; $display("FAIL stall_aw_addr%0d got=%h exp=1000", c, m_aw_addr); end
      if (m_aw_addr !== a0) begin bad++; $display("FAIL stall_aw_stable%0d got=%h exp=%h", c, m_aw_addr, a0); end
      if (m_w_valid !== 1'b0) begin bad++; $display("FAIL stall_w_first%0d got=%b exp=0", c, m_w_valid); end
    end
    m_aw_ready = 1'b1;
    cfg_lsr = 8'h00;
    repeat (20) @(negedge clock);
    total++;
    if (wr_addr_q.size() !== snap + 1) begin
      bad++; $display("FAIL stall_b_count got=%0d exp=1", wr_addr_q.size() - snap);
    end else begin
      total++;
      if (wr_data_q[snap] !== 8'h33) begin bad++; $display("FAIL stall_wdata got=%h exp=33", wr_data_q[snap]); end
    end
  endtask

  task automatic test_tx();
    bit ok;
    int snap, tsnap;
    snap  = wr_addr_q.size();
    tsnap = txr_cnt;
    cfg_lsr = 8'h60;
    drive_tx(8'h41, ok);
    repeat (30) @(negedge clock);
    total += 2;
    if (!ok) begin bad++; $display("FAIL tx_accept got=timeout exp=tx_ready"); end
    if (txr_cnt - tsnap !== 1) begin bad++; $display("FAIL tx_ready_pulses got=%0d exp=1", txr_cnt - tsnap); end
    total++;
    if (wr_addr_q.size() !== snap + 1) begin
      bad++; $display("FAIL tx_write_count got=%0d exp=1", wr_addr_q.size() - snap);
    end else begin
      total += 3;
      if (wr_addr_q[snap] !== 13'h1000) begin bad++; $display("FAIL tx_addr got=%h exp=1000", wr_addr_q[snap]); end
      if (wr_data_q[snap] !== 8'h41)    begin bad++; $display("FAIL tx_data got=%h exp=41", wr_data_q[snap]); end
      if (wr_strb_q[snap] !== 4'h1)     begin bad++; $display("FAIL tx_strb got=%h exp=1", wr_strb_q[snap]); end
    end
    cfg_lsr = 8'h00;
  endtask

  task automatic test_rx();
    int rsnap, lsnap;
    rx_ready = 1'b0;
    rsnap = rbr_cnt;
    cfg_rbr = 8'h5A;
    cfg_lsr = 8'h01;
    for (int i = 0; i < 100; i++) begin
      if (rx_valid) break;
      @(negedge clock);
    end
    total += 3;
    if (rx_valid !== 1'b1) begin bad++; $display("FAIL rx_valid got=%b exp=1", rx_valid); end
    if (rx_data !== 8'h5A) begin bad++; $display("FAIL rx_data got=%h exp=5a", rx_data); end
    if (rbr_cnt - rsnap !== 1) begin bad++; $display("FAIL rx_rbr_reads got=%0d exp=1", rbr_cnt - rsnap); end
    lsnap = lsr_cnt;
    repeat (40) @(negedge clock);
    total += 4;
    if (lsr_cnt - lsnap < 2) begin bad++; $display("FAIL rx_polls_continue got=%0d exp>=2", lsr_cnt - lsnap); end
    if (rbr_cnt - rsnap !== 1) begin bad++; $display("FAIL rx_full_no_rbr got=%0d exp=1", rbr_cnt - rsnap); end
    if (rx_valid !== 1'b1) begin bad++; $display("FAIL rx_hold_valid got=%b exp=1", rx_valid); end
    if (rx_data !== 8'h5A) begin bad++; $display("FAIL rx_hold_data got=%h exp=5a", rx_data); end
    cfg_rbr = 8'hA5;
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_consume got=%b exp=0", rx_valid); end
    for (int i = 0; i < 100; i++) begin
      if (rx_valid) break;
      @(negedge clock);
    end
    total += 3;
    if (rx_valid !== 1'b1) begin bad++; $display("FAIL rx_second_valid got=%b exp=1", rx_valid); end
    if (rx_data !== 8'hA5) begin bad++; $display("FAIL rx_second_data got=%h exp=a5", rx_data); end
    if (rbr_cnt - rsnap !== 2) begin bad++; $display("FAIL rx_second_read got=%0d exp=2", rbr_cnt - rsnap); end
    cfg_lsr = 8'h00;
    rx_ready = 1'b1;
    repeat (30) @(negedge clock);
    rx_ready = 1'b0;
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_drain got=%b exp=0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    int snap;
    bit seen;
    snap = op_q.size();
    rx_ready = 1'b1;
    cfg_rbr  = 8'h3C;
    cfg_lsr  = 8'h61;
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (op_q.size() >= snap + 6) break;
      @(negedge clock);
    end
    total++;
    if (op_q.size() < snap + 6) begin
      bad++; $display("FAIL alt_ops got=%0d exp>=6", op_q.size() - snap);
    end else begin
      for (int k = 1; k < 6; k++) begin
        total++;
        if (op_q[snap+k] === op_q[snap+k-1]) begin
          bad++; $display("FAIL alt_order%0d got=%0d exp=not %0d", k, op_q[snap+k], op_q[snap+k-1]);
        end
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tx_ready) begin seen = 1'b1; break; end
    end
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
    cfg_lsr  = 8'h00;
    total++;
    if (!seen) begin bad++; $display("FAIL alt_tx_drain got=timeout exp=tx_ready"); end
    repeat (30) @(negedge clock);
    rx_ready = 1'b0;
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL alt_slot_empty got=%b exp=0", rx_valid); end
  endtask

  task automatic test_err_reinit();
    logic [12:0] ea [6];
    logic [7:0]  ed [6];
    bit ok;
    bit seen;
    int snap, rsnap;
    ea = '{13'h100C, 13'h1000, 13'h1004, 13'h100C, 13'h1008, 13'h1004};
    ed = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};
    total++;
    if (bus_err !== 1'b0) begin bad++; $display("FAIL err_before got=%b exp=0", bus_err); end
    snap = wr_addr_q.size();
    cfg_b_resp = 2'b10;
    cfg_lsr = 8'h20;
    drive_tx(8'h99, ok);
    for (int i = 0; i < 50; i++) begin
      if (wr_addr_q.size() > snap) break;
      @(negedge clock);
    end
    cfg_lsr = 8'h00;
    cfg_b_resp = 2'b00;
    total += 2;
    if (wr_addr_q.size() !== snap + 1) begin bad++; $display("FAIL err_write_done got=%0d exp=1", wr_addr_q.size() - snap); end
    if (bus_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", bus_err); end
    repeat (20) @(negedge clock);
    total++;
    if (bus_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus_err); end

    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (m_ar_valid && m_ar_addr == 13'h1014) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL reinit_find_lsr got=timeout exp=ar_valid"); end
    snap  = wr_addr_q.size();
    rsnap = rd_addr_q.size();
    reinit = 1'b1;
    @(negedge clock);
    reinit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wr_addr_q.size() > snap) break;
      @(negedge clock);
    end
    total += 3;
    if (rd_addr_q.size() !== rsnap + 1) begin
      bad++; $display("FAIL reinit_read_count got=%0d exp=1", rd_addr_q.size() - rsnap);
    end else begin
      total++;
      if (rd_addr_q[rsnap] !== 13'h1014) begin bad++; $display("FAIL reinit_read_addr got=%h exp=1014", rd_addr_q[rsnap]); end
    end
    if (wr_addr_q.size() <= snap) begin bad++; $display("FAIL reinit_first_write got=none exp=write"); end
    if (init_done !== 1'b0) begin bad++; $display("FAIL reinit_done_clear got=%b exp=0", init_done); end
    for (int i = 0; i < 100; i++) begin
      if (wr_addr_q.size() >= snap + 6) break;
      @(negedge clock);
    end
    @(negedge clock);
    total += 3;
    if (init_done !== 1'b1) begin bad++; $display("FAIL reinit_done_set got=%b exp=1", init_done); end
    if (bus_err !== 1'b1) begin bad++; $display("FAIL reinit_err_kept got=%b exp=1", bus_err); end
    if (wr_addr_q.size() !== snap + 6) begin
      bad++; $display("FAIL reinit_write_count got=%0d exp=6", wr_addr_q.size() - snap);
    end else begin
      for (int k = 0; k < 6; k++) begin
        total += 2;
        if (wr_addr_q[snap+k] !== ea[k]) begin bad++; $display("FAIL reinit_addr%0d got=%h exp=%h", k, wr_addr_q[snap+k], ea[k]); end
        if (wr_data_q[snap+k] !== ed[k]) begin bad++; $display("FAIL reinit_data%0d got=%h exp=%h", k, wr_data_q[snap+k], ed[k]); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rbr_cnt = 0;
    lsr_cnt = 0;
    txr_cnt = 0;
    resetn = 1'b0;
    m_aw_ready = 1'b1;
    m_w_ready  = 1'b1;
    m_ar_ready = 1'b1;
    m_r_resp   = 2'b00;
    cfg_b_resp = 2'b00;
    cfg_lsr    = 8'h00;
    cfg_rbr    = 8'h00;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    rx_ready   = 1'b0;
    reinit     = 1'b0;
    test_reset();
    test_init();
    test_aw_stall();
    test_tx();
    test_rx();
    test_back_to_back();
    test_err_reinit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
